// File: rtl/toggle_rx.sv
// Toggle-coded serial receiver: hunts for a sync byte, then delivers FRAME_LEN payload bytes
// over a VALID/READY handshake. Define TOGGLE_RX_PARITY_EN for a per-byte even-parity bit.
//
// state | meaning
// HUNT  | sliding the shift register against SYNC_WORD on every strobed bit
// RECV  | collecting the 8 data bits of a payload byte
// PAR   | waiting for the even-parity bit of the byte held in rxByte (parity build only)
module toggle_rx #(
   parameter logic [7:0] SYNC_WORD = 8'hA5,
   parameter int         FRAME_LEN = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       D_IN,
   input  logic       D_EN,
   input  logic       READY,
   output logic [7:0] DATA,
   output logic       VALID,
   output logic       SYNCED,
   output logic       OVF,
   output logic       PERR
);

`ifdef TOGGLE_RX_PARITY_EN
   typedef enum logic [1:0] {HUNT, RECV, PAR} state_t;
`else
   typedef enum logic [1:0] {HUNT, RECV} state_t;
`endif

   state_t     state;
   logic       last;
   logic [7:0] shiftReg;
   logic [2:0] bitCnt;
   logic [7:0] byteCnt;

   logic       decBit;
   logic [7:0] srNext;
   logic       byteDone;
   logic [7:0] byteVal;
   logic       lastByte;

   assign decBit   = D_IN ^ last;
   assign srNext   = {decBit, shiftReg[7:1]};
   assign lastByte = (byteCnt == 8'(FRAME_LEN - 1));
   assign SYNCED   = (state == RECV);

`ifdef TOGGLE_RX_PARITY_EN
   logic [7:0] rxByte;
   logic       parOk;

   // Even parity: the 8 data bits plus the parity bit must XOR to zero.
   assign parOk    = ~(^rxByte ^ decBit);
   assign byteDone = D_EN && (state == PAR) && parOk;
   assign byteVal  = rxByte;
`else
   assign byteDone = D_EN && (state == RECV) && (bitCnt == 3'd7);
   assign byteVal  = srNext;
   assign PERR     = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state    <= HUNT;
         last     <= 1'b0;
         shiftReg <= 8'h00;
         bitCnt   <= 3'd0;
         byteCnt  <= 8'h00;
         DATA     <= 8'h00;
         VALID    <= 1'b0;
         OVF      <= 1'b0;
`ifdef TOGGLE_RX_PARITY_EN
         rxByte   <= 8'h00;
         PERR     <= 1'b0;
`endif
      end else begin
`ifdef TOGGLE_RX_PARITY_EN
         PERR <= 1'b0;
`endif
         if (VALID && READY)
            VALID <= 1'b0;

         if (D_EN) begin
            last     <= D_IN;
            shiftReg <= srNext;

            case (state)
               HUNT: begin
                  if (srNext == SYNC_WORD) begin
                     state   <= RECV;
                     bitCnt  <= 3'd0;
                     byteCnt <= 8'h00;
                  end
               end
               RECV: begin
                  bitCnt <= bitCnt + 3'd1;
`ifdef TOGGLE_RX_PARITY_EN
                  if (bitCnt == 3'd7) begin
                     state  <= PAR;
                     rxByte <= srNext;
                  end
`endif
               end
`ifdef TOGGLE_RX_PARITY_EN
               PAR: begin
                  if (!parOk) begin
                     PERR  <= 1'b1;
                     state <= HUNT;
                  end
               end
`endif
               default: state <= HUNT;
            endcase

            // A completed byte overrides the handshake clear above so VALID stays high.
            if (byteDone) begin
               if (!VALID || READY) begin
                  DATA    <= byteVal;
                  VALID   <= 1'b1;
                  byteCnt <= byteCnt + 8'h01;
                  state   <= lastByte ? HUNT : RECV;
               end else begin
                  OVF   <= 1'b1;
                  state <= HUNT;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_toggle_rx.sv
// Directed bench for toggle_rx: table of payload bytes plus hand-written corner sequences.
module tb_toggle_rx;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       D_IN = 1'b0;
   logic       D_EN = 1'b0;
   logic       READY = 1'b0;
   logic [7:0] DATA;
   logic       VALID, SYNCED, OVF, PERR;

   toggle_rx dut (
      .CLK(CLK), .RST(RST), .D_IN(D_IN), .D_EN(D_EN), .READY(READY),
      .DATA(DATA), .VALID(VALID), .SYNCED(SYNCED), .OVF(OVF), .PERR(PERR)
   );

   always #5 CLK = ~CLK;

   int   nCmp = 0;
   int   nErr = 0;
   logic lvl = 1'b0;
   logic pendBit;

   typedef struct {
      bit         newFrame;
      int         gap;
      logic       rdy;
      logic [7:0] din;
      logic [7:0] expData;
      logic       expValid;
      logic       expOvf;
      logic       expSynced;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Line level toggles whenever the decoded bit is 1.
   task automatic sendBit(input logic b, input int gap);
      repeat (gap) begin
         D_EN = 1'b0;
         D_IN = 1'($urandom_range(0, 1));
         tick();
      end
      D_IN = lvl ^ b;
      lvl  = D_IN;
      D_EN = 1'b1;
      tick();
      D_EN = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b, input int gap, input bit holdLast);
      logic [8:0] bits;
      int         n;
`ifdef TOGGLE_RX_PARITY_EN
      n    = 9;
      bits = {^b, b};
`else
      n    = 8;
      bits = {1'b0, b};
`endif
      for (int i = 0; i < n - (holdLast ? 1 : 0); i++)
         sendBit(bits[i], gap);
      pendBit = bits[n-1];
   endtask

   task automatic sendSync();
      logic [7:0] sw;
      sw = 8'hA5;
      for (int i = 0; i < 8; i++)
         sendBit(sw[i], 0);
   endtask

   task automatic doReset();
      RST   = 1'b0;
      D_EN  = 1'b0;
      READY = 1'b0;
      tick();
      RST = 1'b1;
      lvl = 1'b0;
   endtask

   task automatic chkAllZero(input string tag);
      chk({tag, "_data"},   DATA,   8'h00);
      chk({tag, "_valid"},  VALID,  1'b0);
      chk({tag, "_synced"}, SYNCED, 1'b0);
      chk({tag, "_ovf"},    OVF,    1'b0);
      chk({tag, "_perr"},   PERR,   1'b0);
   endtask

   initial begin
      // Frame A: READY high throughout, back-to-back bits.
      vecs[0] = '{1'b1, 0, 1'b1, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 0, 1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 0, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 0, 1'b1, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0};
      // Frame B: READY low, second byte overflows and drops back to HUNT.
      vecs[4] = '{1'b1, 0, 1'b0, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 0, 1'b0, 8'h80, 8'h01, 1'b1, 1'b1, 1'b0};
      // Frame D: strobe gaps with noisy line, sync byte inside payload ignored.
      vecs[6] = '{1'b1, 2, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{1'b0, 2, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[8] = '{1'b0, 2, 1'b1, 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b1};
      vecs[9] = '{1'b0, 2, 1'b1, 8'hC3, 8'hC3, 1'b1, 1'b0, 1'b0};

      doReset();
      chkAllZero("reset");

      doReset();
      sendSync();
      chk("sync_synced", SYNCED, 1'b1);
      chk("sync_valid",  VALID,  1'b0);

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].newFrame) begin
            doReset();
            sendSync();
         end
         READY = vecs[i].rdy;
         sendByte(vecs[i].din, vecs[i].gap, 1'b0);
         chk($sformatf("vec%0d_data", i),   DATA,   vecs[i].expData);
         chk($sformatf("vec%0d_valid", i),  VALID,  vecs[i].expValid);
         chk($sformatf("vec%0d_ovf", i),    OVF,    vecs[i].expOvf);
         chk($sformatf("vec%0d_synced", i), SYNCED, vecs[i].expSynced);
      end

      // Handshake lands in the same cycle the second byte completes.
      doReset();
      sendSync();
      READY = 1'b0;
      sendByte(8'h01, 0, 1'b0);
      chk("same_b1_valid", VALID, 1'b1);
      sendByte(8'h80, 0, 1'b1);
      READY = 1'b1;
      sendBit(pendBit, 0);
      chk("same_valid", VALID, 1'b1);
      chk("same_data",  DATA,  8'h80);
      chk("same_ovf",   OVF,   1'b0);
      tick();
      chk("same_clear", VALID, 1'b0);

      // OVF stays set across a resync and a later good byte.
      doReset();
      sendSync();
      READY = 1'b0;
      sendByte(8'h01, 0, 1'b0);
      sendByte(8'h80, 0, 1'b0);
      chk("sticky_ovf_set", OVF, 1'b1);
      sendSync();
      chk("sticky_resync", SYNCED, 1'b1);
      READY = 1'b1;
      sendByte(8'h3C, 0, 1'b0);
      chk("sticky_data",  DATA,  8'h3C);
      chk("sticky_valid", VALID, 1'b1);
      chk("sticky_ovf",   OVF,   1'b1);

      // Reset on the third bit of byte 2 aborts the frame and drops the pending byte.
      doReset();
      sendSync();
      READY = 1'b0;
      sendByte(8'h01, 0, 1'b0);
      sendBit(1'b0, 0);
      sendBit(1'b0, 0);
      D_IN = lvl;
      D_EN = 1'b1;
      RST  = 1'b0;
      tick();
      RST  = 1'b1;
      D_EN = 1'b0;
      lvl  = 1'b0;
      chkAllZero("midrst");
      for (int i = 0; i < 4; i++)
         sendBit(1'b0, 0);
      sendBit(1'b1, 0);
      READY = 1'b1;
      sendByte(8'h3C, 0, 1'b0);
      chk("midrst_nosync",  SYNCED, 1'b0);
      chk("midrst_novalid", VALID,  1'b0);
      sendSync();
      chk("midrst_resync", SYNCED, 1'b1);
      sendByte(8'h5A, 0, 1'b0);
      chk("midrst_data",  DATA,  8'h5A);
      chk("midrst_valid", VALID, 1'b1);

`ifdef TOGGLE_RX_PARITY_EN
      doReset();
      sendSync();
      READY = 1'b1;
      sendByte(8'h03, 0, 1'b1);
      sendBit(1'b1, 0);
      chk("perr_pulse",  PERR,   1'b1);
      chk("perr_valid",  VALID,  1'b0);
      chk("perr_synced", SYNCED, 1'b0);
      tick();
      chk("perr_end",    PERR,   1'b0);
      doReset();
      sendSync();
      READY = 1'b1;
      sendByte(8'h03, 0, 1'b0);
      chk("par_ok_valid", VALID, 1'b1);
      chk("par_ok_data",  DATA,  8'h03);
      chk("par_ok_perr",  PERR,  1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
